// File: rtl/id_ctrl_stage_pkg.sv
// Shared definitions for the ID control stage: ALU function codes, PC source
// codes, opcode/funct constants, the control bundle and the mul/div FSM states.
package id_ctrl_stage_pkg;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_MUL = 6'b000010;
    localparam logic [5:0] ALU_DIV = 6'b000100;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_NEQ = 6'b110001;
    localparam logic [5:0] ALU_LT  = 6'b110101;
    localparam logic [5:0] ALU_LEZ = 6'b111101;
    localparam logic [5:0] ALU_LTZ = 6'b111011;
    localparam logic [5:0] ALU_GTZ = 6'b111111;

    localparam logic [2:0] PC_SEQ   = 3'd0;
    localparam logic [2:0] PC_BR    = 3'd1;
    localparam logic [2:0] PC_J     = 3'd2;
    localparam logic [2:0] PC_JR    = 3'd3;
    localparam logic [2:0] PC_IRQ   = 3'd4;
    localparam logic [2:0] PC_UNDEF = 3'd5;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_MULTU= 6'h19;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_DIVU = 6'h1B;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [2:0] pc_src;
        logic [1:0] reg_dst;
        logic       reg_wr;
        logic       alu_src1;
        logic       alu_src2;
        logic [5:0] alu_fun;
        logic       sign;
        logic       mem_wr;
        logic       mem_rd;
        logic [1:0] mem_to_reg;
        logic       ext_op;
        logic       lu_op;
    } ctrl_bundle_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/id_ctrl_stage_ctrl_decode.sv
// Purely combinational instruction decode into the control bundle, with IRQ and
// undefined-instruction overrides applied on top of the normal table.
module ctrl_decode
    import id_ctrl_stage_pkg::*;
(
    input  logic [31:0]  instr_i,
    input  logic         irq_i,
    input  logic         muldiv_en_i,
    output ctrl_bundle_t bundle_o,
    output logic         is_muldiv_o
);

    logic [5:0]   op;
    logic [5:0]   fn;
    logic         undef;
    logic         md;
    ctrl_bundle_t b;
    logic         unused_fields;

    assign op            = instr_i[31:26];
    assign fn            = instr_i[5:0];
    assign unused_fields = ^instr_i[25:6];

    always_comb begin
        b        = '0;
        b.sign   = 1'b1;
        b.ext_op = 1'b1;
        undef    = 1'b0;
        md       = 1'b0;
        case (op)
            OP_RTYPE: begin
                b.reg_wr = 1'b1;
                case (fn)
                    FN_ADD, FN_ADDU: begin b.alu_fun = ALU_ADD; b.sign = ~fn[0]; end
                    FN_SUB, FN_SUBU: begin b.alu_fun = ALU_SUB; b.sign = ~fn[0]; end
                    FN_AND:          b.alu_fun = ALU_AND;
                    FN_OR:           b.alu_fun = ALU_OR;
                    FN_XOR:          b.alu_fun = ALU_XOR;
                    FN_NOR:          b.alu_fun = ALU_NOR;
                    FN_SLT, FN_SLTU: begin b.alu_fun = ALU_LT; b.sign = ~fn[0]; end
                    FN_SLL:          begin b.alu_fun = ALU_SLL; b.alu_src1 = 1'b1; end
                    FN_SRL:          begin b.alu_fun = ALU_SRL; b.alu_src1 = 1'b1; end
                    FN_SRA:          begin b.alu_fun = ALU_SRA; b.alu_src1 = 1'b1; end
                    FN_JR:           begin b.pc_src = PC_JR; b.reg_wr = 1'b0; end
                    FN_JALR:         begin b.pc_src = PC_JR; b.mem_to_reg = 2'd2; end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        // Result lands in HI/LO, so no register-file write.
                        md        = muldiv_en_i;
                        undef     = ~muldiv_en_i;
                        b.reg_wr  = 1'b0;
                        b.alu_fun = fn[1] ? ALU_DIV : ALU_MUL;
                        b.sign    = ~fn[0];
                    end
                    default:         undef = 1'b1;
                endcase
            end
            OP_REGIMM: begin b.pc_src = PC_BR; b.alu_fun = ALU_LTZ; end
            OP_BEQ:    begin b.pc_src = PC_BR; b.alu_fun = ALU_EQ;  end
            OP_BNE:    begin b.pc_src = PC_BR; b.alu_fun = ALU_NEQ; end
            OP_BLEZ:   begin b.pc_src = PC_BR; b.alu_fun = ALU_LEZ; end
            OP_BGTZ:   begin b.pc_src = PC_BR; b.alu_fun = ALU_GTZ; end
            OP_J:      b.pc_src = PC_J;
            OP_JAL:    begin b.pc_src = PC_J; b.reg_wr = 1'b1; b.reg_dst = 2'd2; b.mem_to_reg = 2'd2; end
            OP_ADDI, OP_ADDIU: begin
                b.reg_wr = 1'b1; b.reg_dst = 2'd1; b.alu_src2 = 1'b1; b.sign = ~op[0];
            end
            OP_SLTI, OP_SLTIU: begin
                b.reg_wr = 1'b1; b.reg_dst = 2'd1; b.alu_src2 = 1'b1;
                b.alu_fun = ALU_LT; b.sign = ~op[0];
            end
            OP_ANDI:   begin b.reg_wr = 1'b1; b.reg_dst = 2'd1; b.alu_src2 = 1'b1; b.alu_fun = ALU_AND; b.ext_op = 1'b0; end
            OP_LUI:    begin b.reg_wr = 1'b1; b.reg_dst = 2'd1; b.alu_src2 = 1'b1; b.lu_op = 1'b1; end
            OP_LW:     begin b.reg_wr = 1'b1; b.reg_dst = 2'd1; b.alu_src2 = 1'b1; b.mem_rd = 1'b1; b.mem_to_reg = 2'd1; end
            OP_SW:     begin b.alu_src2 = 1'b1; b.mem_wr = 1'b1; end
            default:   undef = 1'b1;
        endcase

        bundle_o    = b;
        is_muldiv_o = md & ~irq_i;
        // IRQ outranks an undefined instruction; both trap to the $k0 handler path.
        if (irq_i || undef) begin
            bundle_o            = '0;
            bundle_o.pc_src     = irq_i ? PC_IRQ : PC_UNDEF;
            bundle_o.reg_dst    = 2'd3;
            bundle_o.reg_wr     = 1'b1;
            bundle_o.mem_to_reg = irq_i ? 2'd3 : 2'd2;
        end
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered ID control stage: valid/ready handshake around ctrl_decode, a
// multi-cycle mul/div occupancy FSM and a synchronised, maskable IRQ request.
module id_ctrl_stage
    import id_ctrl_stage_pkg::*;
#(
    parameter int ENABLE_MULDIV   = 1,
    parameter int MULDIV_CYCLES   = 4,
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        kernel_mode,
    input  logic        irq_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  pc_src,
    output logic [1:0]  reg_dst,
    output logic        reg_wr,
    output logic        alu_src1,
    output logic        alu_src2,
    output logic [5:0]  alu_fun,
    output logic        sign,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [1:0]  mem_to_reg,
    output logic        ext_op,
    output logic        lu_op,
    output logic        irq_taken,
    output logic        busy
);

    localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

    ctrl_bundle_t dec_bundle, bundle_q, bundle_d;
    logic         dec_muldiv;
    md_state_e    state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         out_valid_q, out_valid_d;
    logic         irq_taken_q;
    logic         irq_pending_q, irq_pending_d;
    logic         irq_last_q, irq_edge;
    logic [IRQ_SYNC_STAGES-1:0] sync_q, sync_in;
    logic         accept, irq_attach;

    for (genvar gi = 0; gi < IRQ_SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_in[gi] = irq_in;
        end else begin : g_rest
            assign sync_in[gi] = sync_q[gi-1];
        end
    end

    assign irq_edge   = sync_q[IRQ_SYNC_STAGES-1] & ~irq_last_q;
    // A transfer in the same cycle as flush is discarded and must not consume the IRQ.
    assign accept     = in_valid & in_ready & ~flush;
    assign irq_attach = accept & irq_pending_q & ~kernel_mode;

    ctrl_decode u_decode (
        .instr_i     (instr),
        .irq_i       (irq_pending_q & ~kernel_mode),
        .muldiv_en_i (ENABLE_MULDIV != 0),
        .bundle_o    (dec_bundle),
        .is_muldiv_o (dec_muldiv)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bundle_q      <= '0;
            out_valid_q   <= 1'b0;
            irq_taken_q   <= 1'b0;
            irq_pending_q <= 1'b0;
            irq_last_q    <= 1'b0;
            sync_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bundle_q      <= bundle_d;
            out_valid_q   <= out_valid_d;
            irq_taken_q   <= irq_attach;
            irq_pending_q <= irq_pending_d;
            irq_last_q    <= sync_q[IRQ_SYNC_STAGES-1];
            sync_q        <= sync_in;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bundle_d      = bundle_q;
        out_valid_d   = out_valid_q;
        irq_pending_d = irq_edge ? 1'b1 : (irq_attach ? 1'b0 : irq_pending_q);
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && dec_muldiv) begin
                    state_d = MD_BUSY;
                    cnt_d   = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            bundle_d    = dec_bundle;
            out_valid_d = ~dec_muldiv;
        end
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
            cnt_d       = '0;
        end
    end

    always_comb begin
        busy     = (state_q == MD_BUSY);
        in_ready = ~busy & (~out_valid_q | out_ready);
    end

    // Write enables are gated so a bubble can never commit a stale bundle.
    assign out_valid  = out_valid_q;
    assign irq_taken  = irq_taken_q;
    assign pc_src     = bundle_q.pc_src;
    assign reg_dst    = bundle_q.reg_dst;
    assign reg_wr     = bundle_q.reg_wr & out_valid_q;
    assign alu_src1   = bundle_q.alu_src1;
    assign alu_src2   = bundle_q.alu_src2;
    assign alu_fun    = bundle_q.alu_fun;
    assign sign       = bundle_q.sign;
    assign mem_wr     = bundle_q.mem_wr & out_valid_q;
    assign mem_rd     = bundle_q.mem_rd & out_valid_q;
    assign mem_to_reg = bundle_q.mem_to_reg;
    assign ext_op     = bundle_q.ext_op;
    assign lu_op      = bundle_q.lu_op;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed-vector bench for id_ctrl_stage; a second instance with mul/div
// disabled checks that those functs trap as undefined.
module tb_id_ctrl_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, kernel_mode, irq_in, flush, out_ready;
    logic [31:0] instr;

    logic        in_ready, out_valid, reg_wr, alu_src1, alu_src2, sign, mem_wr, mem_rd;
    logic        ext_op, lu_op, irq_taken, busy;
    logic [2:0]  pc_src;
    logic [1:0]  reg_dst, mem_to_reg;
    logic [5:0]  alu_fun;

    logic        n_in_ready, n_out_valid, n_reg_wr, n_alu_src1, n_alu_src2, n_sign, n_mem_wr, n_mem_rd;
    logic        n_ext_op, n_lu_op, n_irq_taken, n_busy;
    logic [2:0]  n_pc_src;
    logic [1:0]  n_reg_dst, n_mem_to_reg;
    logic [5:0]  n_alu_fun;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] I_LW   = 32'h8C820004;
    localparam logic [31:0] I_ADD  = 32'h00851020;
    localparam logic [31:0] I_MULT = 32'h00850018;
    localparam logic [31:0] I_UNDF = 32'hFC000000;

    always #5 clk = ~clk;

    id_ctrl_stage #(.ENABLE_MULDIV(1), .MULDIV_CYCLES(4), .IRQ_SYNC_STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .kernel_mode(kernel_mode), .irq_in(irq_in), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .pc_src(pc_src), .reg_dst(reg_dst), .reg_wr(reg_wr),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_fun(alu_fun), .sign(sign),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_to_reg(mem_to_reg), .ext_op(ext_op),
        .lu_op(lu_op), .irq_taken(irq_taken), .busy(busy)
    );

    id_ctrl_stage #(.ENABLE_MULDIV(0), .MULDIV_CYCLES(4), .IRQ_SYNC_STAGES(2)) u_dut_nomd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready), .instr(instr),
        .kernel_mode(kernel_mode), .irq_in(irq_in), .flush(flush), .out_valid(n_out_valid),
        .out_ready(out_ready), .pc_src(n_pc_src), .reg_dst(n_reg_dst), .reg_wr(n_reg_wr),
        .alu_src1(n_alu_src1), .alu_src2(n_alu_src2), .alu_fun(n_alu_fun), .sign(n_sign),
        .mem_wr(n_mem_wr), .mem_rd(n_mem_rd), .mem_to_reg(n_mem_to_reg), .ext_op(n_ext_op),
        .lu_op(n_lu_op), .irq_taken(n_irq_taken), .busy(n_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; kernel_mode = 1'b0; irq_in = 1'b0;
        flush = 1'b0; out_ready = 1'b1; instr = '0;
        step(); step(); step();

        // reset state: {bundle}, out_valid, irq_taken, busy
        chk("rst_bundle", {pc_src, reg_dst, reg_wr, alu_src1, alu_src2, alu_fun, sign,
                           mem_wr, mem_rd, mem_to_reg, ext_op, lu_op}, 32'h0);
        chk("rst_ctl", {out_valid, irq_taken, busy}, 32'h0);
        reset = 1'b0;
        step();
        chk("rdy_after_rst", in_ready, 1);

        // lw: one-cycle latency
        instr = I_LW; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lw_valid", out_valid, 1);
        chk("lw_fields", {mem_rd, mem_to_reg, reg_dst, alu_src2, reg_wr, mem_wr},
                         {26'h0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0});
        chk("lw_alu", alu_fun, 6'b000000);
        step();
        chk("bubble_valid", out_valid, 0);
        chk("bubble_we", {reg_wr, mem_wr, mem_rd}, 3'b000);

        // mult: 3 busy cycles, issue in the 4th; no-muldiv copy traps at once
        instr = I_MULT; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("md_c1", {busy, in_ready, out_valid}, 3'b100);
        chk("nomd_undef", {n_pc_src, n_reg_dst, n_reg_wr, n_alu_src1, n_alu_src2, n_alu_fun,
                           n_sign, n_mem_wr, n_mem_rd, n_mem_to_reg, n_ext_op, n_lu_op,
                           n_out_valid, n_irq_taken, n_busy, n_in_ready},
                          {3'd5, 2'd3, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,
                           2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        step();
        chk("md_c2", {busy, in_ready, out_valid}, 3'b100);
        step();
        chk("md_c3", {busy, in_ready, out_valid}, 3'b100);
        step();
        chk("md_c4", {busy, out_valid}, 2'b01);
        chk("md_bundle", {alu_fun, sign, reg_wr, pc_src}, {6'b000010, 1'b1, 1'b0, 3'd0});
        step();
        chk("md_drained", out_valid, 0);

        // undefined opcode 0x3F
        instr = I_UNDF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("undef", {pc_src, reg_dst, reg_wr, mem_to_reg, mem_wr, mem_rd},
                     {3'd5, 2'd3, 1'b1, 2'd2, 1'b0, 1'b0});
        step();

        // backpressure: bundle holds for add while a lw waits upstream
        out_ready = 1'b0; instr = I_ADD; in_valid = 1'b1;
        step();
        instr = I_LW;
        chk("bp_c1", {out_valid, in_ready, reg_wr, mem_rd, alu_fun, pc_src, reg_dst},
                     {1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 3'd0, 2'd0});
        step();
        chk("bp_c2", {out_valid, in_ready, reg_wr, mem_rd, alu_src2},
                     {1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("bp_flushed", {out_valid, reg_wr}, 2'b00);

        // flush discards a same-cycle transfer
        out_ready = 1'b1; instr = I_LW; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_discard", {out_valid, mem_rd}, 2'b00);

        // IRQ: masked in kernel mode, taken on the next user-mode instruction
        irq_in = 1'b1;
        step(); step(); step(); step();
        kernel_mode = 1'b1; instr = I_ADD; in_valid = 1'b1;
        step();
        in_valid = 1'b0; kernel_mode = 1'b0;
        chk("irq_masked", {out_valid, pc_src, mem_to_reg, irq_taken}, {1'b1, 3'd0, 2'd0, 1'b0});
        step();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("irq_take", {out_valid, pc_src, reg_dst, reg_wr, mem_to_reg, irq_taken},
                        {1'b1, 3'd4, 2'd3, 1'b1, 2'd3, 1'b1});
        step();
        chk("irq_pulse_end", {irq_taken, out_valid}, 2'b00);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("irq_cleared", {pc_src, irq_taken, out_valid}, {3'd0, 1'b0, 1'b1});
        irq_in = 1'b0;
        step();

        // reset in the middle of a mul/div
        instr = I_MULT; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rst_md_busy", busy, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_md_out", {pc_src, reg_dst, reg_wr, alu_src1, alu_src2, alu_fun, sign,
                           mem_wr, mem_rd, mem_to_reg, ext_op, lu_op, out_valid, busy, irq_taken}, 32'h0);
        step(); step(); step();
        chk("rst_md_noissue", {out_valid, busy}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
